shield_ctrl: RTL and testbench

//  Game-logic controller for the shield power-up and its draw_shield instance.
//  - Decides when the pickup is shown (en) and when the player holds it (is_shielded).
//  - Detects the pickup event from the player position.
//  - Times the shield in frames, with a blinking warning before it expires.
//  - Absorbs one hit while the shield is held.
//  - Respawns the pickup after a cooldown.

---
 rtl/shield_ctrl.sv | 164 ++++++++++++++++
 tb/tb_shield_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shield_ctrl.sv
// ============================================================================
// Module   : shield_ctrl
// Brief    : Shield power-up game logic. Handles pickup visibility, pickup
//            detection, a framed lifetime with blink warning, single-hit
//            absorption and respawn cooldown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shield_ctrl #(
    parameter int XPOS           = 300,
    parameter int YPOS           = 200,
    parameter int OFFSET         = 64,
    parameter int PLAYER_SIZE    = 64,
    parameter int SHIELD_FRAMES  = 600,
    parameter int BLINK_FRAMES   = 120,
    parameter int BLINK_PERIOD   = 8,
    parameter int RESPAWN_FRAMES = 900
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_game,
    input  logic        vblnk,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic        hit,
    output logic        en,
    output logic        is_shielded,
    output logic        shield_vis,
    output logic        player_hit,
    output logic        hit_absorbed,
    output logic [9:0]  time_left
);

    localparam int                c_PH_W     = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST  = c_PH_W'(BLINK_PERIOD - 1);
    localparam logic [9:0]        c_SHIELD   = 10'(SHIELD_FRAMES);
    localparam logic [9:0]        c_BLINK    = 10'(BLINK_FRAMES);
    localparam logic [9:0]        c_RESPAWN  = 10'(RESPAWN_FRAMES);
    localparam logic [11:0]       c_X_LO     = 12'(XPOS);
    localparam logic [11:0]       c_X_HI     = 12'(XPOS + OFFSET);
    localparam logic [11:0]       c_Y_LO     = 12'(YPOS);
    localparam logic [11:0]       c_Y_HI     = 12'(YPOS + OFFSET);
    localparam logic [11:0]       c_PSIZE    = 12'(PLAYER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_AVAILABLE = 3'd1,
        S_ACTIVE    = 3'd2,
        S_BLINK     = 3'd3,
        S_COOLDOWN  = 3'd4
    } state_t;

    state_t              r_state;
    logic [9:0]          r_timer;
    logic [c_PH_W-1:0]   r_phase;
    logic                r_vblnk_q;

    logic                w_tick;
    logic                w_ovl;
    logic [11:0]         w_px;
    logic [11:0]         w_py;
    logic [9:0]          w_timer_dec;

    // Widened by one bit so that position + size cannot wrap.
    assign w_px        = {1'b0, player_x};
    assign w_py        = {1'b0, player_y};
    assign w_ovl       = (w_px < c_X_HI) && ((w_px + c_PSIZE) > c_X_LO)
                      && (w_py < c_Y_HI) && ((w_py + c_PSIZE) > c_Y_LO);
    assign w_tick      = vblnk & ~r_vblnk_q;
    assign w_timer_dec = (r_timer == 10'd0) ? 10'd0 : (r_timer - 10'd1);
    assign time_left   = r_timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= 10'd0;
            r_phase      <= '0;
            r_vblnk_q    <= 1'b0;
            en           <= 1'b0;
            is_shielded  <= 1'b0;
            shield_vis   <= 1'b0;
            player_hit   <= 1'b0;
            hit_absorbed <= 1'b0;
        end else begin
            r_vblnk_q    <= vblnk;
            player_hit   <= 1'b0;
            hit_absorbed <= 1'b0;
            if (!start_game) begin
                r_state     <= S_IDLE;
                r_timer     <= 10'd0;
                r_phase     <= '0;
                en          <= 1'b0;
                is_shielded <= 1'b0;
                shield_vis  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_AVAILABLE;
                        en      <= 1'b1;
                    end
                    S_AVAILABLE: begin
                        if (hit) begin
                            player_hit <= 1'b1;
                        end
                        if (w_ovl) begin
                            r_state     <= S_ACTIVE;
                            r_timer     <= c_SHIELD;
                            en          <= 1'b0;
                            is_shielded <= 1'b1;
                            shield_vis  <= 1'b1;
                        end
                    end
                    S_ACTIVE, S_BLINK: begin
                        // A hit beats a same-cycle expiry: the shield is spent absorbing it.
                        if (hit || (w_tick && (w_timer_dec == 10'd0))) begin
                            hit_absorbed <= hit;
                            r_state      <= S_COOLDOWN;
                            r_timer      <= c_RESPAWN;
                            is_shielded  <= 1'b0;
                            shield_vis   <= 1'b0;
                        end else if (w_tick) begin
                            r_timer <= w_timer_dec;
                            if (r_state == S_ACTIVE) begin
                                if (w_timer_dec == c_BLINK) begin
                                    r_state    <= S_BLINK;
                                    r_phase    <= '0;
                                    shield_vis <= 1'b1;
                                end
                            end else if (r_phase == c_PH_LAST) begin
                                r_phase    <= '0;
                                shield_vis <= ~shield_vis;
                            end else begin
                                r_phase <= r_phase + c_PH_W'(1);
                            end
                        end
                    end
                    S_COOLDOWN: begin
                        if (hit) begin
                            player_hit <= 1'b1;
                        end
                        if (w_tick) begin
                            r_timer <= w_timer_dec;
                            if (w_timer_dec == 10'd0) begin
                                r_state <= S_AVAILABLE;
                                en      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_timer     <= 10'd0;
                        en          <= 1'b0;
                        is_shielded <= 1'b0;
                        shield_vis  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shield_ctrl.sv
// ============================================================================
// Module   : tb_shield_ctrl
// Brief    : Self-checking bench for shield_ctrl: vector table, directed
//            lifetime/cooldown sequences and randomized traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shield_ctrl;

    localparam int XPOS = 300, YPOS = 200, OFFSET = 64, PLAYER_SIZE = 64;
    localparam int SHIELD_FRAMES = 600, BLINK_FRAMES = 120, BLINK_PERIOD = 8;
    localparam int RESPAWN_FRAMES = 900;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_game = 1'b0;
    logic        vblnk = 1'b0;
    logic [10:0] player_x = '0;
    logic [10:0] player_y = '0;
    logic        hit = 1'b0;
    logic        en, is_shielded, shield_vis, player_hit, hit_absorbed;
    logic [9:0]  time_left;

    int checks = 0;
    int errs   = 0;

    shield_ctrl #(
        .XPOS(XPOS), .YPOS(YPOS), .OFFSET(OFFSET), .PLAYER_SIZE(PLAYER_SIZE),
        .SHIELD_FRAMES(SHIELD_FRAMES), .BLINK_FRAMES(BLINK_FRAMES),
        .BLINK_PERIOD(BLINK_PERIOD), .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .vblnk(vblnk),
        .player_x(player_x), .player_y(player_y), .hit(hit),
        .en(en), .is_shielded(is_shielded), .shield_vis(shield_vis),
        .player_hit(player_hit), .hit_absorbed(hit_absorbed), .time_left(time_left)
    );

    always #5 clk = ~clk;

    // Reference model: 0 off, 1 pickup shown, 2 shield held, 3 respawn wait.
    int m_mode = 0, m_life = 0, m_cool = 0;
    bit m_vq = 0;
    bit e_en, e_sh, e_vis, e_ph, e_ha;
    int e_tl;

    function automatic bit overlaps(int x, int y);
        return (x < XPOS + OFFSET) && (x + PLAYER_SIZE > XPOS)
            && (y < YPOS + OFFSET) && (y + PLAYER_SIZE > YPOS);
    endfunction

    task automatic model_step();
        bit tick;
        tick = vblnk && !m_vq;
        e_ph = 0;
        e_ha = 0;
        if (rst) begin
            m_vq = 0; m_mode = 0; m_life = 0; m_cool = 0;
        end else begin
            m_vq = vblnk;
            if (!start_game) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (hit) e_ph = 1;
                if (overlaps(int'(player_x), int'(player_y))) begin
                    m_mode = 2; m_life = SHIELD_FRAMES;
                end
            end else if (m_mode == 2) begin
                if (hit) begin
                    e_ha = 1; m_mode = 3; m_cool = RESPAWN_FRAMES;
                end else if (tick) begin
                    m_life = m_life - 1;
                    if (m_life == 0) begin
                        m_mode = 3; m_cool = RESPAWN_FRAMES;
                    end
                end
            end else begin
                if (hit) e_ph = 1;
                if (tick) begin
                    if (m_cool > 0) m_cool = m_cool - 1;
                    if (m_cool == 0) m_mode = 1;
                end
            end
        end
        e_en  = (m_mode == 1);
        e_sh  = (m_mode == 2);
        e_vis = (m_mode == 2) && ((m_life > BLINK_FRAMES)
                || (((BLINK_FRAMES - m_life) / BLINK_PERIOD) % 2 == 0));
        e_tl  = (m_mode == 2) ? m_life : (m_mode == 3) ? m_cool : 0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("model.en", 32'(en), 32'(e_en));
        chk("model.is_shielded", 32'(is_shielded), 32'(e_sh));
        chk("model.shield_vis", 32'(shield_vis), 32'(e_vis));
        chk("model.player_hit", 32'(player_hit), 32'(e_ph));
        chk("model.hit_absorbed", 32'(hit_absorbed), 32'(e_ha));
        chk("model.time_left", 32'(time_left), 32'(e_tl));
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) begin
            vblnk = 1'b1; cyc();
            vblnk = 1'b0; cyc();
        end
    endtask

    task automatic place(int x, int y);
        player_x = 11'(x);
        player_y = 11'(y);
    endtask

    typedef struct {
        bit r, s, v; int x, y; bit h;
        bit en, sh, vis, ph, ha; int tl;
    } vec_t;

    function automatic vec_t mkv(bit r, bit s, bit v, int x, int y, bit h,
                                 bit en_e, bit sh_e, bit vis_e, bit ph_e, bit ha_e, int tl_e);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.x = x; t.y = y; t.h = h;
        t.en = en_e; t.sh = sh_e; t.vis = vis_e; t.ph = ph_e; t.ha = ha_e; t.tl = tl_e;
        return t;
    endfunction

    vec_t tbl[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int toggles;
        logic prev_vis;

        //               rst s  v  x    y    h   en sh vis ph ha  tl
        tbl[0]  = mkv(1, 0, 0, 0,   0,   0,  0, 0, 0,  0, 0,  0);
        tbl[1]  = mkv(0, 1, 0, 0,   0,   0,  1, 0, 0,  0, 0,  0);
        tbl[2]  = mkv(0, 1, 0, 0,   0,   1,  1, 0, 0,  1, 0,  0);
        tbl[3]  = mkv(0, 1, 0, 0,   0,   0,  1, 0, 0,  0, 0,  0);
        tbl[4]  = mkv(0, 1, 0, 364, 200, 0,  1, 0, 0,  0, 0,  0);
        tbl[5]  = mkv(0, 1, 0, 300, 136, 0,  1, 0, 0,  0, 0,  0);
        tbl[6]  = mkv(0, 1, 0, 237, 200, 0,  0, 1, 1,  0, 0,  600);
        tbl[7]  = mkv(0, 1, 1, 237, 200, 0,  0, 1, 1,  0, 0,  599);
        tbl[8]  = mkv(0, 1, 1, 237, 200, 0,  0, 1, 1,  0, 0,  599);
        tbl[9]  = mkv(0, 1, 0, 237, 200, 0,  0, 1, 1,  0, 0,  599);
        tbl[10] = mkv(0, 1, 0, 237, 200, 1,  0, 0, 0,  0, 1,  900);
        tbl[11] = mkv(0, 1, 0, 237, 200, 1,  0, 0, 0,  1, 0,  900);
        tbl[12] = mkv(0, 0, 0, 0,   0,   0,  0, 0, 0,  0, 0,  0);
        tbl[13] = mkv(0, 1, 0, 0,   0,   0,  1, 0, 0,  0, 0,  0);

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].r; start_game = tbl[i].s; vblnk = tbl[i].v;
            place(tbl[i].x, tbl[i].y); hit = tbl[i].h;
            cyc();
            chk($sformatf("tbl[%0d].en", i), 32'(en), 32'(tbl[i].en));
            chk($sformatf("tbl[%0d].is_shielded", i), 32'(is_shielded), 32'(tbl[i].sh));
            chk($sformatf("tbl[%0d].shield_vis", i), 32'(shield_vis), 32'(tbl[i].vis));
            chk($sformatf("tbl[%0d].player_hit", i), 32'(player_hit), 32'(tbl[i].ph));
            chk($sformatf("tbl[%0d].hit_absorbed", i), 32'(hit_absorbed), 32'(tbl[i].ha));
            chk($sformatf("tbl[%0d].time_left", i), 32'(time_left), 32'(tbl[i].tl));
        end
        hit = 1'b0;

        // Full lifetime, blink count and respawn
        frames(100);
        chk("idle_frames.en", 32'(en), 32'd1);
        place(280, 190); cyc();
        chk("pickup.is_shielded", 32'(is_shielded), 32'd1);
        chk("pickup.time_left", 32'(time_left), 32'd600);
        place(0, 0);
        frames(480);
        chk("blink_entry.time_left", 32'(time_left), 32'd120);
        chk("blink_entry.shield_vis", 32'(shield_vis), 32'd1);
        toggles = 0;
        prev_vis = shield_vis;
        for (int i = 0; i < 240; i++) begin
            vblnk = (i % 2 == 0); cyc();
            if (shield_vis !== prev_vis) toggles++;
            prev_vis = shield_vis;
        end
        vblnk = 1'b0;
        chk("blink.toggles", 32'(toggles), 32'd15);
        chk("expire.is_shielded", 32'(is_shielded), 32'd0);
        chk("expire.time_left", 32'(time_left), 32'd900);
        frames(899);
        chk("cool899.en", 32'(en), 32'd0);
        chk("cool899.time_left", 32'(time_left), 32'd1);
        place(364, 200);
        vblnk = 1'b1; cyc();
        chk("respawn.en", 32'(en), 32'd1);
        vblnk = 1'b0; cyc();
        chk("edge_touch.is_shielded", 32'(is_shielded), 32'd0);

        // Hit absorbed once, then the next hit costs a life
        place(280, 190); cyc();
        place(0, 0); hit = 1'b1; cyc();
        chk("absorb.hit_absorbed", 32'(hit_absorbed), 32'd1);
        chk("absorb.player_hit", 32'(player_hit), 32'd0);
        hit = 1'b0; cyc();
        chk("absorb.pulse_len", 32'(hit_absorbed), 32'd0);
        hit = 1'b1; cyc();
        chk("second_hit.player_hit", 32'(player_hit), 32'd1);
        hit = 1'b0; cyc();

        // start_game drop mid-ACTIVE, hit+pickup together, rst mid-BLINK
        place(280, 190); start_game = 1'b0; cyc();
        start_game = 1'b1; cyc();
        cyc();
        place(0, 0); cyc();
        start_game = 1'b0; cyc();
        chk("drop.all_zero", {en, is_shielded, shield_vis, player_hit, hit_absorbed, time_left}, 32'd0);
        start_game = 1'b1; cyc();
        place(280, 190); hit = 1'b1; cyc();
        chk("hit_ovl.player_hit", 32'(player_hit), 32'd1);
        chk("hit_ovl.is_shielded", 32'(is_shielded), 32'd1);
        hit = 1'b0; place(0, 0);
        frames(485);
        rst = 1'b1; cyc();
        chk("rst_blink.all_zero", {en, is_shielded, shield_vis, player_hit, hit_absorbed, time_left}, 32'd0);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 20000; i++) begin
            rst        = ($urandom_range(0, 3999) == 0);
            start_game = ($urandom_range(0, 4999) != 0);
            vblnk      = $urandom_range(0, 1) == 1;
            hit        = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1)
                place($urandom_range(200, 400), $urandom_range(100, 300));
            else
                place($urandom_range(0, 2047), $urandom_range(0, 2047));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

`default_nettype wire
